div_clk_monitor: RTL and testbench

DIV_CLK_MONITOR -- requirements
Module: div_clk_monitor

---
 rtl/div_clk_monitor.sv | 136 +++++++++++++
 tb/tb_div_clk_monitor.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/div_clk_monitor.sv
// rtl/div_clk_monitor.sv - synchronizes a divided clock, measures its half period, tracks lock and timeout
module div_clk_monitor #(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 16,
  parameter int LOCK_COUNT  = 4,
  parameter int TIMEOUT     = 1000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             div_clk_in,
  input  logic             meas_ready,
  output logic             rise_pulse,
  output logic             fall_pulse,
  output logic [CNT_W-1:0] half_period,
  output logic             meas_valid,
  output logic             locked,
  output logic             timeout,
  output logic             overrun
);

  localparam int               MW          = $clog2(LOCK_COUNT + 1);
  localparam logic [MW-1:0]    LOCK_LAST   = MW'(LOCK_COUNT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX     = '1;
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, ACQUIRE, LOCKED, LOST} state_t;

  state_t                 state;
  state_t                 state_next;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_out;
  logic                   prev;
  logic                   edge_seen;
  logic                   report;
  logic                   same_interval;
  logic                   timed_out;
  logic [CNT_W-1:0]       cnt;
  logic [CNT_W-1:0]       last_meas;
  logic [CNT_W-1:0]       last_meas_next;
  logic [MW-1:0]          match_cnt;
  logic [MW-1:0]          match_next;

  assign sync_out      = sync_q[SYNC_STAGES-1];
  assign edge_seen     = sync_out != prev;
  assign report        = edge_seen && (state == ACQUIRE || state == LOCKED);
  assign same_interval = cnt == last_meas;
  assign timed_out     = cnt >= TIMEOUT_CNT;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      match_cnt <= '0;
      last_meas <= '0;
      locked    <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      state     <= state_next;
      match_cnt <= match_next;
      last_meas <= last_meas_next;
      locked    <= state_next == LOCKED;
      timeout   <= state_next == LOST;
    end
  end

  // An edge always takes priority over the timeout check in the same cycle.
  always_comb begin
    state_next     = state;
    match_next     = match_cnt;
    last_meas_next = last_meas;
    case (state)
      IDLE, LOST: begin
        if (edge_seen) begin
          state_next     = ACQUIRE;
          match_next     = '0;
          last_meas_next = '0;
        end
      end
      ACQUIRE: begin
        if (edge_seen) begin
          last_meas_next = cnt;
          if (same_interval) begin
            match_next = match_cnt + 1'b1;
            if (match_next == LOCK_LAST) state_next = LOCKED;
          end else begin
            match_next = '0;
          end
        end else if (timed_out) begin
          state_next = LOST;
        end
      end
      LOCKED: begin
        if (edge_seen) begin
          last_meas_next = cnt;
          if (!same_interval) begin
            state_next = ACQUIRE;
            match_next = '0;
          end
        end else if (timed_out) begin
          state_next = LOST;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q      <= '0;
      prev        <= 1'b0;
      rise_pulse  <= 1'b0;
      fall_pulse  <= 1'b0;
      cnt         <= '0;
      half_period <= '0;
      meas_valid  <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      sync_q     <= {sync_q[SYNC_STAGES-2:0], div_clk_in};
      prev       <= sync_out;
      rise_pulse <= sync_out & ~prev;
      fall_pulse <= ~sync_out & prev;
      if (edge_seen)           cnt <= CNT_ONE;
      else if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
      // A stalled consumer keeps the older value; the newer one is lost.
      if (report && (!meas_valid || meas_ready)) begin
        half_period <= cnt;
        meas_valid  <= 1'b1;
      end else if (report) begin
        overrun <= 1'b1;
      end else if (meas_ready) begin
        meas_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_div_clk_monitor.sv
// tb/tb_div_clk_monitor.sv - directed self-checking bench for div_clk_monitor
module tb_div_clk_monitor;

  logic        clk;
  logic        rst_n;
  logic        div_clk_in;
  logic        meas_ready;
  logic        rise_pulse;
  logic        fall_pulse;
  logic [15:0] half_period;
  logic        meas_valid;
  logic        locked;
  logic        timeout;
  logic        overrun;

  int n_checks;
  int n_pass;
  int n_fail;
  int phase;
  int next_toggle;
  int half;

  div_clk_monitor #(
    .SYNC_STAGES(2),
    .CNT_W      (16),
    .LOCK_COUNT (4),
    .TIMEOUT    (1000)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .div_clk_in (div_clk_in),
    .meas_ready (meas_ready),
    .rise_pulse (rise_pulse),
    .fall_pulse (fall_pulse),
    .half_period(half_period),
    .meas_valid (meas_valid),
    .locked     (locked),
    .timeout    (timeout),
    .overrun    (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s at phase %0d: observed=%0d expected=%0d", tag, phase, got, exp);
    end
  endtask

  // Inputs change 1ns after a rising edge; outputs are read at the same point.
  task automatic step();
    if (phase == next_toggle) begin
      div_clk_in  = ~div_clk_in;
      next_toggle = next_toggle + half;
    end
    @(posedge clk);
    #1;
    phase++;
  endtask

  task automatic run_to(input int p);
    while (phase < p) step();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rise"},    32'(rise_pulse),  0);
    check({tag, "_fall"},    32'(fall_pulse),  0);
    check({tag, "_half"},    32'(half_period), 0);
    check({tag, "_valid"},   32'(meas_valid),  0);
    check({tag, "_locked"},  32'(locked),      0);
    check({tag, "_timeout"}, 32'(timeout),     0);
    check({tag, "_overrun"}, 32'(overrun),     0);
  endtask

  initial begin
    n_checks    = 0;
    n_pass      = 0;
    n_fail      = 0;
    rst_n       = 1'b0;
    div_clk_in  = 1'b0;
    meas_ready  = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    check_all_zero("reset");
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Toggle every 2 cycles: edges at phases 0,2,...,10; results appear 3 cycles later.
    phase = 0; next_toggle = 0; half = 2;
    run_to(3);  check("e1_rise", 32'(rise_pulse), 1);
                check("e1_fall", 32'(fall_pulse), 0);
                check("e1_no_meas", 32'(meas_valid), 0);
    run_to(4);  check("e1_rise_width", 32'(rise_pulse), 0);
    run_to(5);  check("e2_fall", 32'(fall_pulse), 1);
                check("e2_valid", 32'(meas_valid), 1);
                check("e2_half", 32'(half_period), 2);
    run_to(6);  check("e2_valid_clears", 32'(meas_valid), 0);
    run_to(10); check("e4_not_locked", 32'(locked), 0);
    run_to(11); check("e5_locked", 32'(locked), 1);
                check("e5_valid", 32'(meas_valid), 1);

    // Switch to 10-cycle half period starting at phase 12 (e7 still closes a 2-interval).
    half = 10;
    run_to(15); check("e7_half", 32'(half_period), 2);
                check("e7_rise", 32'(rise_pulse), 1);
    run_to(24); check("e8_pre_locked", 32'(locked), 1);
    run_to(25); check("e8_unlock", 32'(locked), 0);
                check("e8_half", 32'(half_period), 10);
                check("e8_fall", 32'(fall_pulse), 1);
                check("e8_rise_low", 32'(rise_pulse), 0);
    run_to(26); check("e8_fall_width", 32'(fall_pulse), 0);
    run_to(35); check("e9_rise", 32'(rise_pulse), 1);
                check("e9_fall_low", 32'(fall_pulse), 0);
    run_to(45); check("e10_fall", 32'(fall_pulse), 1);
    run_to(55); check("e11_relock", 32'(locked), 1);
                check("e11_half", 32'(half_period), 10);

    // One 12-cycle interval while locked.
    next_toggle = 64;
    run_to(66); check("e12_pre_locked", 32'(locked), 1);
    run_to(67); check("e12_unlock", 32'(locked), 0);
                check("e12_half", 32'(half_period), 12);

    // Relock at 10 (edges 74..104), then hold the input.
    run_to(107); check("e16_locked", 32'(locked), 1);
                 check("e16_half", 32'(half_period), 10);
    next_toggle = 1200;
    run_to(1106); check("pre_timeout", 32'(timeout), 0);
                  check("pre_timeout_locked", 32'(locked), 1);
    run_to(1107); check("timeout_set", 32'(timeout), 1);
                  check("timeout_unlock", 32'(locked), 0);
    run_to(1203); check("e17_timeout_clear", 32'(timeout), 0);
                  check("e17_no_meas", 32'(meas_valid), 0);
                  check("e17_rise", 32'(rise_pulse), 1);
                  check("e17_half_kept", 32'(half_period), 10);

    // Stalled consumer across edges at 1210 (interval 10) and 1217 (interval 7).
    run_to(1205); meas_ready = 1'b0;
    run_to(1213); check("e18_valid", 32'(meas_valid), 1);
                  check("e18_half", 32'(half_period), 10);
                  check("e18_no_overrun", 32'(overrun), 0);
    next_toggle = 1217;
    run_to(1220); check("e19_valid_held", 32'(meas_valid), 1);
                  check("e19_half_held", 32'(half_period), 10);
                  check("e19_overrun", 32'(overrun), 1);
    run_to(1222); meas_ready = 1'b1;
    run_to(1223); check("ready_clears_valid", 32'(meas_valid), 0);
                  check("overrun_sticky", 32'(overrun), 1);
    run_to(1230); check("e20_valid", 32'(meas_valid), 1);
                  check("e20_half", 32'(half_period), 10);
                  check("e20_overrun_sticky", 32'(overrun), 1);

    // One-cycle reset mid-interval; next edge is at 1237.
    run_to(1233); rst_n = 1'b0;
    run_to(1234); rst_n = 1'b1;
    check_all_zero("midreset");
    run_to(1240); check("e21_rise", 32'(rise_pulse), 1);
                  check("e21_no_meas", 32'(meas_valid), 0);
    run_to(1250); check("e22_valid", 32'(meas_valid), 1);
                  check("e22_half", 32'(half_period), 10);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
